// File: rtl/vx_sfu_rsp_arb_if.sv
// Handshake bundle for the SFU response arbiter.
// The slave modport is the arbiter's view.
// The master modport is the view of the response sources plus the gather stage.
interface vx_sfu_rsp_arb_if #(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64,
    parameter int OUT_DEPTH  = 2
);
    localparam int SEL_W = $clog2(NUM_INPUTS);
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

    logic [NUM_INPUTS-1:0]       valid_in;
    logic [NUM_INPUTS-1:0]       ready_in;
    logic [NUM_INPUTS*DATAW-1:0] data_in;
    logic                        valid_out;
    logic                        ready_out;
    logic [DATAW-1:0]            data_out;
    logic [SEL_W-1:0]            sel_out;
    logic [CNT_W-1:0]            count_out;

    modport master (
        output valid_in, data_in, ready_out,
        input  ready_in, valid_out, data_out, sel_out, count_out
    );

    modport slave (
        input  valid_in, data_in, ready_out,
        output ready_in, valid_out, data_out, sel_out, count_out
    );
endinterface

// File: rtl/vx_sfu_rsp_arb.sv
// SFU response arbiter.
// Picks one of NUM_INPUTS response sources per cycle and queues the winner's
// payload and source index in a small output FIFO.
// ARB_MODE selects the policy: 0 = round-robin, 1 = fixed priority.
// A per-input wait counter force-grants any source that has waited STARVE_MAX
// cycles. The counters freeze while the FIFO is backpressured.
// Optional feature: define SFU_RSP_ARB_PERF_EN to add the perf_stall_cycles and
// perf_starve_grants counters.
module vx_sfu_rsp_arb #(
    parameter int NUM_INPUTS = 2,
    parameter int DATAW      = 64,
    parameter int ARB_MODE   = 0,
    parameter int OUT_DEPTH  = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_sfu_rsp_arb_if.slave       bus
`ifdef SFU_RSP_ARB_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_starve_grants
`endif
);
    localparam int SEL_W = $clog2(NUM_INPUTS);
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [3:0]       STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(OUT_DEPTH);

    // FIFO storage and state
    logic [DATAW-1:0] data_mem_r [OUT_DEPTH];
    logic [SEL_W-1:0] sel_mem_r  [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Arbitration state
    logic [SEL_W-1:0] rr_ptr_r;
    logic [3:0]       wait_cnt_r [NUM_INPUTS];

    // Combinational arbitration and handshake signals
    logic                  valid_out_s;
    logic                  pop_s;
    logic                  full_s;
    logic                  can_push_s;
    logic                  blocked_s;
    logic                  any_valid_s;
    logic                  push_s;
    logic                  starved_found_s;
    logic [SEL_W-1:0]      starved_idx_s;
    logic [SEL_W-1:0]      fp_idx_s;
    logic [SEL_W-1:0]      rr_idx_s;
    logic [SEL_W-1:0]      rr_cand_s;
    logic [SEL_W-1:0]      sel_idx_s;
    logic [SEL_W-1:0]      rr_next_s;
    logic [NUM_INPUTS-1:0] grant_oh_s;
    logic [DATAW-1:0]      push_data_s;

    assign valid_out_s = (count_r != {CNT_W{1'b0}});
    assign pop_s       = valid_out_s & bus.ready_out;
    assign full_s      = (count_r == FULL_CNT);
    // A full FIFO can still accept a push when the head leaves in the same cycle.
    assign can_push_s  = ~full_s | pop_s;
    assign blocked_s   = ~can_push_s;
    assign any_valid_s = |bus.valid_in;
    // While reset is low the arbiter must not accept anything.
    assign push_s      = reset & any_valid_s & can_push_s;

    // Candidate selection: the lowest starved input, the lowest valid input, and the first valid input at or after rr_ptr
    always_comb begin
        starved_found_s = 1'b0;
        starved_idx_s   = {SEL_W{1'b0}};
        fp_idx_s        = {SEL_W{1'b0}};
        rr_idx_s        = rr_ptr_r;
        rr_cand_s       = {SEL_W{1'b0}};
        // Each loop runs from the highest index down, so the lowest qualifying index is the last one written.
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (bus.valid_in[i] && (wait_cnt_r[i] == STARVE_LIM)) begin
                starved_found_s = 1'b1;
                starved_idx_s   = SEL_W'(i);
            end else begin
                starved_found_s = starved_found_s;
            end
            if (bus.valid_in[i]) begin
                fp_idx_s = SEL_W'(i);
            end else begin
                fp_idx_s = fp_idx_s;
            end
        end
        // The round-robin search walks the offset k downward, so the smallest offset from rr_ptr is the last one written.
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            rr_cand_s = SEL_W'((int'(rr_ptr_r) + k) % NUM_INPUTS);
            if (bus.valid_in[rr_cand_s]) begin
                rr_idx_s = rr_cand_s;
            end else begin
                rr_idx_s = rr_idx_s;
            end
        end
    end

    // Final choice: a starved input overrides the configured policy
    always_comb begin
        if (starved_found_s) begin
            sel_idx_s = starved_idx_s;
        end else if (ARB_MODE == 1) begin
            sel_idx_s = fp_idx_s;
        end else begin
            sel_idx_s = rr_idx_s;
        end
    end

    // One-hot grant, the winner's payload, and the next round-robin pointer
    always_comb begin
        grant_oh_s  = {NUM_INPUTS{1'b0}};
        push_data_s = {DATAW{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_idx_s == SEL_W'(i)) begin
                grant_oh_s[i] = push_s;
                push_data_s   = bus.data_in[i*DATAW +: DATAW];
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
        if (sel_idx_s == SEL_W'(NUM_INPUTS - 1)) begin
            rr_next_s = {SEL_W{1'b0}};
        end else begin
            rr_next_s = sel_idx_s + SEL_W'(1);
        end
    end

    assign bus.ready_in  = grant_oh_s;
    assign bus.valid_out = valid_out_s;
    assign bus.count_out = count_r;
    // The head is forced to zero when the FIFO is empty, so reset reads back as zero.
    assign bus.data_out  = valid_out_s ? data_mem_r[rd_ptr_r] : {DATAW{1'b0}};
    assign bus.sel_out   = valid_out_s ? sel_mem_r[rd_ptr_r]  : {SEL_W{1'b0}};

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            rr_ptr_r <= {SEL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                rr_ptr_r <= rr_next_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO payload storage, unreset because reads are gated by occupancy
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_r[wr_ptr_r] <= push_data_s;
            sel_mem_r[wr_ptr_r]  <= sel_idx_s;
        end
    end

    // Per-input starvation counters, frozen while the FIFO is backpressured
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wait_cnt_r[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!bus.valid_in[i] || grant_oh_s[i]) begin
                    wait_cnt_r[i] <= 4'd0;
                end else if (!blocked_s && (wait_cnt_r[i] != STARVE_LIM)) begin
                    wait_cnt_r[i] <= wait_cnt_r[i] + 4'd1;
                end else begin
                    wait_cnt_r[i] <= wait_cnt_r[i];
                end
            end
        end
    end

`ifdef SFU_RSP_ARB_PERF_EN
    logic force_grant_s;
    assign force_grant_s = push_s & starved_found_s;

    // Perf counters: stalled request cycles and starvation force-grants
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cycles  <= 32'd0;
            perf_starve_grants <= 32'd0;
        end else begin
            if (any_valid_s && !push_s) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (force_grant_s) begin
                perf_starve_grants <= perf_starve_grants + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_sfu_rsp_arb.sv
// Directed testbench for vx_sfu_rsp_arb.
// dut_a: 2 inputs, round-robin, STARVE_MAX 15.
// dut_b: 3 inputs, fixed priority, STARVE_MAX 3.
// Both instances use a 2-entry FIFO.
// The perf counters are checked when SFU_RSP_ARB_PERF_EN is defined.
module tb_vx_sfu_rsp_arb;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks_total  = 0;
    int   checks_passed = 0;

    always #5 clk = ~clk;

    vx_sfu_rsp_arb_if #(.NUM_INPUTS(2), .DATAW(64), .OUT_DEPTH(2)) bus_a ();
    vx_sfu_rsp_arb_if #(.NUM_INPUTS(3), .DATAW(64), .OUT_DEPTH(2)) bus_b ();

`ifdef SFU_RSP_ARB_PERF_EN
    logic [31:0] perf_stall_a, perf_starve_a, perf_stall_b, perf_starve_b;
`endif

    vx_sfu_rsp_arb #(.NUM_INPUTS(2), .DATAW(64), .ARB_MODE(0), .OUT_DEPTH(2), .STARVE_MAX(15)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
`ifdef SFU_RSP_ARB_PERF_EN
        , .perf_stall_cycles(perf_stall_a), .perf_starve_grants(perf_starve_a)
`endif
    );

    vx_sfu_rsp_arb #(.NUM_INPUTS(3), .DATAW(64), .ARB_MODE(1), .OUT_DEPTH(2), .STARVE_MAX(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
`ifdef SFU_RSP_ARB_PERF_EN
        , .perf_stall_cycles(perf_stall_b), .perf_starve_grants(perf_starve_b)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc();
        cyc();
        bus_a.valid_in = 2'b11;
        bus_b.valid_in = 3'b111;
        #1;
        checks_total++;
        if (bus_a.valid_out !== 1'b0) $display("FAIL rst_valid_out: got %b expected 0", bus_a.valid_out); else checks_passed++;
        checks_total++;
        if (bus_a.ready_in !== 2'b00) $display("FAIL rst_ready_in_a: got %b expected 00", bus_a.ready_in); else checks_passed++;
        checks_total++;
        if (bus_b.ready_in !== 3'b000) $display("FAIL rst_ready_in_b: got %b expected 000", bus_b.ready_in); else checks_passed++;
        checks_total++;
        if (bus_a.count_out !== 2'd0) $display("FAIL rst_count: got %0d expected 0", bus_a.count_out); else checks_passed++;
        checks_total++;
        if (bus_a.sel_out !== 1'b0) $display("FAIL rst_sel: got %0d expected 0", bus_a.sel_out); else checks_passed++;
        checks_total++;
        if (bus_a.data_out !== 64'd0) $display("FAIL rst_data: got %h expected 0", bus_a.data_out); else checks_passed++;
        bus_a.valid_in = 2'b00;
        bus_b.valid_in = 3'b000;
        reset = 1'b1;
        cyc();
        checks_total++;
        if (bus_a.count_out !== 2'd0) $display("FAIL rst_release_count: got %0d expected 0", bus_a.count_out); else checks_passed++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic        exp_sel;
        logic [63:0] exp_data;
        bus_a.ready_out = 1'b1;
        bus_a.valid_in  = 2'b11;
        bus_a.data_in   = {64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00A0};
        for (int i = 0; i < 4; i++) begin
            exp_rdy  = ((i % 2) == 0) ? 2'b01 : 2'b10;
            exp_sel  = ((i % 2) == 0) ? 1'b0 : 1'b1;
            exp_data = ((i % 2) == 0) ? 64'h0000_0000_0000_00A0 : 64'h0000_0000_0000_00B1;
            #1;
            checks_total++;
            if (bus_a.ready_in !== exp_rdy) $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus_a.ready_in, exp_rdy); else checks_passed++;
            cyc();
            checks_total++;
            if (bus_a.valid_out !== 1'b1 || bus_a.sel_out !== exp_sel || bus_a.data_out !== exp_data)
                $display("FAIL rr_head[%0d]: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h",
                         i, bus_a.valid_out, bus_a.sel_out, bus_a.data_out, exp_sel, exp_data);
            else checks_passed++;
            checks_total++;
            if (bus_a.count_out !== 2'd1) $display("FAIL rr_count[%0d]: got %0d expected 1", i, bus_a.count_out); else checks_passed++;
        end
        bus_a.valid_in = 2'b00;
        cyc();
        checks_total++;
        if (bus_a.count_out !== 2'd0 || bus_a.valid_out !== 1'b0)
            $display("FAIL rr_drain: got count=%0d v=%b expected count=0 v=0", bus_a.count_out, bus_a.valid_out);
        else checks_passed++;
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_rdy;
        bus_a.ready_out = 1'b0;
        bus_a.valid_in  = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus_a.data_in = {64'd0, 64'h100 + 64'(k)};
            exp_rdy = (k < 2) ? 2'b01 : 2'b00;
            #1;
            checks_total++;
            if (bus_a.ready_in !== exp_rdy) $display("FAIL bp_ready[%0d]: got %b expected %b", k, bus_a.ready_in, exp_rdy); else checks_passed++;
            cyc();
        end
        checks_total++;
        if (bus_a.count_out !== 2'd2 || bus_a.valid_out !== 1'b1 || bus_a.sel_out !== 1'b0 || bus_a.data_out !== 64'h100)
            $display("FAIL bp_full: got count=%0d v=%b sel=%0d data=%h expected count=2 v=1 sel=0 data=100",
                     bus_a.count_out, bus_a.valid_out, bus_a.sel_out, bus_a.data_out);
        else checks_passed++;
        checks_total++;
        if (bus_a.ready_in !== 2'b00) $display("FAIL bp_full_ready: got %b expected 00", bus_a.ready_in); else checks_passed++;
        bus_a.data_in   = {64'd0, 64'h1FF};
        bus_a.ready_out = 1'b1;
        #1;
        checks_total++;
        if (bus_a.ready_in !== 2'b01) $display("FAIL bp_pop_push_ready: got %b expected 01", bus_a.ready_in); else checks_passed++;
        cyc();
        bus_a.ready_out = 1'b0;
        #1;
        checks_total++;
        if (bus_a.count_out !== 2'd2 || bus_a.data_out !== 64'h101)
            $display("FAIL bp_pop_push: got count=%0d data=%h expected count=2 data=101", bus_a.count_out, bus_a.data_out);
        else checks_passed++;
        bus_a.valid_in  = 2'b00;
        bus_a.ready_out = 1'b1;
        cyc();
        checks_total++;
        if (bus_a.count_out !== 2'd1 || bus_a.data_out !== 64'h1FF)
            $display("FAIL bp_drain1: got count=%0d data=%h expected count=1 data=1ff", bus_a.count_out, bus_a.data_out);
        else checks_passed++;
        cyc();
        checks_total++;
        if (bus_a.count_out !== 2'd0) $display("FAIL bp_drain2: got %0d expected 0", bus_a.count_out); else checks_passed++;
        bus_a.ready_out = 1'b0;
    endtask

    task automatic test_starvation();
        logic [2:0]  exp_rdy;
        logic [1:0]  exp_sel;
        logic [63:0] exp_data;
        bus_b.ready_out = 1'b1;
        bus_b.valid_in  = 3'b101;
        bus_b.data_in   = {64'h0000_0000_0000_00C2, 64'd0, 64'h0000_0000_0000_00A0};
        for (int i = 0; i < 8; i++) begin
            exp_rdy  = ((i % 4) == 3) ? 3'b100 : 3'b001;
            exp_sel  = ((i % 4) == 3) ? 2'd2 : 2'd0;
            exp_data = ((i % 4) == 3) ? 64'h0000_0000_0000_00C2 : 64'h0000_0000_0000_00A0;
            #1;
            checks_total++;
            if (bus_b.ready_in !== exp_rdy) $display("FAIL starve_ready[%0d]: got %b expected %b", i, bus_b.ready_in, exp_rdy); else checks_passed++;
            cyc();
            checks_total++;
            if (bus_b.sel_out !== exp_sel || bus_b.data_out !== exp_data)
                $display("FAIL starve_head[%0d]: got sel=%0d data=%h expected sel=%0d data=%h",
                         i, bus_b.sel_out, bus_b.data_out, exp_sel, exp_data);
            else checks_passed++;
        end
        bus_b.valid_in = 3'b000;
        cyc();
        checks_total++;
        if (bus_b.count_out !== 2'd0) $display("FAIL starve_drain: got %0d expected 0", bus_b.count_out); else checks_passed++;
        bus_b.ready_out = 1'b0;
    endtask

    task automatic test_async_reset();
        bus_a.ready_out = 1'b0;
        bus_a.valid_in  = 2'b11;
        cyc();
        cyc();
        checks_total++;
        if (bus_a.count_out !== 2'd2) $display("FAIL ar_fill: got %0d expected 2", bus_a.count_out); else checks_passed++;
        #2;
        reset = 1'b0;
        #1;
        checks_total++;
        if (bus_a.valid_out !== 1'b0 || bus_a.count_out !== 2'd0)
            $display("FAIL ar_immediate: got v=%b count=%0d expected v=0 count=0", bus_a.valid_out, bus_a.count_out);
        else checks_passed++;
        checks_total++;
        if (bus_a.ready_in !== 2'b00) $display("FAIL ar_ready: got %b expected 00", bus_a.ready_in); else checks_passed++;
`ifdef SFU_RSP_ARB_PERF_EN
        checks_total++;
        if (perf_stall_a !== 32'd0 || perf_starve_a !== 32'd0)
            $display("FAIL ar_perf: got stall=%0d starve=%0d expected 0 0", perf_stall_a, perf_starve_a);
        else checks_passed++;
`endif
        cyc();
        reset = 1'b1;
        bus_a.ready_out = 1'b1;
        #1;
        checks_total++;
        if (bus_a.ready_in !== 2'b01) $display("FAIL ar_first_grant: got %b expected 01", bus_a.ready_in); else checks_passed++;
        cyc();
        checks_total++;
        if (bus_a.valid_out !== 1'b1 || bus_a.sel_out !== 1'b0)
            $display("FAIL ar_first_head: got v=%b sel=%0d expected v=1 sel=0", bus_a.valid_out, bus_a.sel_out);
        else checks_passed++;
        bus_a.valid_in = 2'b00;
        cyc();
        bus_a.ready_out = 1'b0;
    endtask

    task automatic test_stall_freeze();
        logic [2:0] exp_rdy;
        bus_b.ready_out = 1'b0;
        bus_b.valid_in  = 3'b010;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks_total++;
            if (bus_b.ready_in !== 3'b010) $display("FAIL sf_fill[%0d]: got %b expected 010", k, bus_b.ready_in); else checks_passed++;
            cyc();
        end
        checks_total++;
        if (bus_b.count_out !== 2'd2) $display("FAIL sf_full: got %0d expected 2", bus_b.count_out); else checks_passed++;
        bus_b.valid_in = 3'b011;
        for (int k = 0; k < 20; k++) begin
            #1;
            checks_total++;
            if (bus_b.ready_in !== 3'b000) $display("FAIL sf_blocked[%0d]: got %b expected 000", k, bus_b.ready_in); else checks_passed++;
            cyc();
        end
`ifdef SFU_RSP_ARB_PERF_EN
        checks_total++;
        if (perf_stall_b !== 32'd20 || perf_starve_b !== 32'd0)
            $display("FAIL sf_perf: got stall=%0d starve=%0d expected 20 0", perf_stall_b, perf_starve_b);
        else checks_passed++;
`endif
        bus_b.ready_out = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_rdy = (j == 3) ? 3'b010 : 3'b001;
            #1;
            checks_total++;
            if (bus_b.ready_in !== exp_rdy) $display("FAIL sf_release[%0d]: got %b expected %b", j, bus_b.ready_in, exp_rdy); else checks_passed++;
            cyc();
        end
`ifdef SFU_RSP_ARB_PERF_EN
        checks_total++;
        if (perf_stall_b !== 32'd20 || perf_starve_b !== 32'd1)
            $display("FAIL sf_perf_after: got stall=%0d starve=%0d expected 20 1", perf_stall_b, perf_starve_b);
        else checks_passed++;
`endif
        bus_b.valid_in = 3'b000;
        cyc();
        cyc();
        checks_total++;
        if (bus_b.count_out !== 2'd0) $display("FAIL sf_drain: got %0d expected 0", bus_b.count_out); else checks_passed++;
    endtask

    initial begin
        bus_a.valid_in  = 2'b00;
        bus_a.data_in   = 128'd0;
        bus_a.ready_out = 1'b0;
        bus_b.valid_in  = 3'b000;
        bus_b.data_in   = 192'd0;
        bus_b.ready_out = 1'b0;
        #2;
        reset = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_starvation();
        test_async_reset();
        test_stall_freeze();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/vx_sfu_rsp_arb.md
VX_SFU_RSP_ARB -- requirements
Module: VX_sfu_rsp_arb

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: number of SFU sub-unit response sources; legal range 2..8.
REQ-002 SHALL have parameter DATAW, default 64: width of each commit payload in bits.
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 SHALL have parameter OUT_DEPTH, default 2: output FIFO entries; power of two, at least 2.
REQ-005 SHALL have parameter STARVE_MAX, default 15: wait cycles after which a waiting input is force-granted; 4-bit counter.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port valid_in  input  NUM_INPUTS  per-source response valid.
REQ-009 SHALL have port ready_in  output  NUM_INPUTS  per-source accept; one-hot or zero.
REQ-010 SHALL have port data_in  input  NUM_INPUTS*DATAW  per-source payload, source i at bits [i*DATAW +: DATAW].
REQ-011 SHALL have port valid_out  output  1  FIFO head valid.
REQ-012 SHALL have port ready_out  input  1  downstream (gather stage) accept.
REQ-013 SHALL have port data_out  output  DATAW  FIFO head payload.
REQ-014 SHALL have port sel_out  output  CLOG2(NUM_INPUTS)  source index of FIFO head.
REQ-015 SHALL have port count_out  output  CLOG2(OUT_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 SHALL grant at most one input per cycle; transfer on input i occurs when valid_in[i] and ready_in[i] are both 1.
REQ-017 SHALL assert a grant only when FIFO not full, or full with pop (valid_out and ready_out) in the same cycle.
REQ-018 SHALL not make ready_in depend on any valid_in other than through the arbitration choice (no combinational loop via ready_out beyond REQ-017).
REQ-019 SHALL write granted payload and its index into the FIFO; valid_out rises the cycle after acceptance (1-cycle latency), no combinational bypass.
REQ-020 SHALL pop the head on valid_out and ready_out; simultaneous push and pop SHALL leave count_out unchanged.
REQ-021 SHALL hold data_out and sel_out stable while valid_out=1 and ready_out=0; values are don't-care when valid_out=0.
REQ-022 SHALL, in round-robin mode, search from pointer rr_ptr upward with wrap-around and set rr_ptr to granted index+1 (mod NUM_INPUTS); rr_ptr unchanged if no grant.
REQ-023 SHALL, in fixed-priority mode, grant the lowest-index valid input, subject to REQ-024.
REQ-024 SHALL keep per-input wait counter: increment (saturating at STARVE_MAX) when valid_in=1 and not granted and FIFO not blocked; clear on grant or valid_in=0; any input at STARVE_MAX is granted next, lowest index first among starved.
REQ-025 SHALL freeze wait counters while FIFO is full without pop (backpressure is not starvation).
REQ-026 SHALL wrap FIFO read/write pointers modulo OUT_DEPTH.

Reset
REQ-027 SHALL, while reset=0, drive valid_out=0, ready_in=0, count_out=0, sel_out=0, data_out=0.
REQ-028 SHALL clear FIFO pointers, rr_ptr and all wait counters on reset assertion, asynchronously; in-flight FIFO contents are discarded.
REQ-029 SHALL resume arbitration on the first rising clk edge after reset deasserts, with rr_ptr=0.

Configuration
REQ-030 SHALL, when SFU_RSP_ARB_PERF_EN is defined, add outputs perf_stall_cycles (32b, counts cycles with any valid_in=1 and no grant) and perf_starve_grants (32b, counts force-grants from REQ-024), both reset to 0 and wrapping at 2^32.
REQ-031 SHALL, without SFU_RSP_ARB_PERF_EN, omit these ports and counters entirely; all other behaviour identical.

Verification
REQ-032 SHALL cover: NUM_INPUTS=2, ARB_MODE=0, both valid continuously, ready_out=1 -> sel_out sequence 0,1,0,1 starting 1 cycle after first grant.
REQ-033 SHALL cover: OUT_DEPTH=2, ready_out=0, input 0 valid 4 cycles -> 2 accepts, count_out=2, ready_in[0]=0 thereafter; ready_out=1 one cycle -> one pop plus one push, count_out stays 2.
REQ-034 SHALL cover: ARB_MODE=1, NUM_INPUTS=3, STARVE_MAX=3, inputs 0 and 2 valid continuously, ready_out=1 -> input 2 granted after 3 losing cycles, then input 0 resumes.
REQ-035 SHALL cover: reset driven low while count_out=2 -> valid_out=0 and count_out=0 immediately without clk edge; after release first grant goes to input 0 in RR mode.
REQ-036 SHALL cover: ready_out=0 with FIFO full for 20 cycles, input 1 valid -> wait counter stays 0, no force-grant, perf_stall_cycles increments by 20 when SFU_RSP_ARB_PERF_EN defined.
